// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 64-word RAM.
// One command is in flight at a time; read data returns two cycles after grant.
module ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_r_w,
    output logic              ram_enable,
    output logic              ram_ce,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT
    } state_t;

    state_t state;
    logic   last_b;
    logic   owner_b;
    logic   pick_b;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        pick_b = 1'b0;
        unique case (1'b1)
            a_req && b_req:  pick_b = !last_b;
            b_req && !a_req: pick_b = 1'b1;
            default:         pick_b = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            owner_b     <= 1'b0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            rdata       <= '0;
            ram_add     <= '0;
            ram_data_in <= '0;
            ram_r_w     <= 1'b0;
            ram_enable  <= 1'b0;
            ram_ce      <= 1'b0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        ram_add     <= pick_b ? b_addr  : a_addr;
                        ram_data_in <= pick_b ? b_wdata : a_wdata;
                        ram_r_w     <= pick_b ? b_we    : a_we;
                        ram_enable  <= 1'b1;
                        ram_ce      <= 1'b1;
                        a_gnt       <= !pick_b;
                        b_gnt       <= pick_b;
                        owner_b     <= pick_b;
                        last_b      <= pick_b;
                        state       <= ACCESS;
                    end else begin
                        ram_add     <= '0;
                        ram_data_in <= '0;
                        ram_r_w     <= 1'b0;
                        ram_enable  <= 1'b0;
                        ram_ce      <= 1'b0;
                    end
                end
                ACCESS: begin
                    ram_enable <= 1'b0;
                    ram_ce     <= 1'b0;
                    state      <= ram_r_w ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    rdata    <= ram_data_out;
                    a_rvalid <= !owner_b;
                    b_rvalid <= owner_b;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, reset-abort sequence,
// and random traffic against a transaction-level model with a RAM model.
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_data_in;
    logic          ram_r_w, ram_enable, ram_ce;
    logic [DW-1:0] ram_data_out;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata),
        .ram_add(ram_add), .ram_data_in(ram_data_in), .ram_r_w(ram_r_w),
        .ram_enable(ram_enable), .ram_ce(ram_ce),
        .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output RAM seen by the arbiter
    logic          clr;
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            ram_data_out <= '0;
        end else if (ram_enable && ram_ce) begin
            if (ram_r_w) ram[ram_add] <= ram_data_in;
            else ram_data_out <= ram[ram_add];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model
    typedef struct {
        int            cyc;
        logic          who;
        logic [DW-1:0] data;
    } rd_t;

    int            cyc = 0;
    int            next_acc = 0;
    logic          last_b;
    logic [DW-1:0] mm [64];
    logic [DW-1:0] exp_rd;
    rd_t           pend[$];
    logic          order[$];

    task automatic model_reset();
        next_acc = cyc;
        last_b   = 1'b1;
        exp_rd   = '0;
        pend.delete();
    endtask

    task automatic step_check();
        logic          eag, ebg, earv, ebrv, wb, we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        rd_t           r;
        eag = 1'b0; ebg = 1'b0; earv = 1'b0; ebrv = 1'b0;
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
            earv   = !pend[0].who;
            ebrv   = pend[0].who;
            exp_rd = pend[0].data;
            void'(pend.pop_front());
        end
        if (cyc >= next_acc && (a_req || b_req)) begin
            wb     = b_req && (!a_req || !last_b);
            last_b = wb;
            eag    = !wb;
            ebg    = wb;
            order.push_back(wb);
            we = wb ? b_we : a_we;
            ad = wb ? b_addr : a_addr;
            wd = wb ? b_wdata : a_wdata;
            chk("m_ram_add", 32'(ram_add), 32'(ad));
            chk("m_ram_r_w", 32'(ram_r_w), 32'(we));
            if (we) begin
                chk("m_ram_data_in", 32'(ram_data_in), 32'(wd));
                mm[ad]   = wd;
                next_acc = cyc + 2;
            end else begin
                r.cyc  = cyc + 2;
                r.who  = wb;
                r.data = mm[ad];
                pend.push_back(r);
                next_acc = cyc + 3;
            end
        end
        chk($sformatf("m_a_gnt c%0d", cyc), 32'(a_gnt), 32'(eag));
        chk($sformatf("m_b_gnt c%0d", cyc), 32'(b_gnt), 32'(ebg));
        chk($sformatf("m_a_rvalid c%0d", cyc), 32'(a_rvalid), 32'(earv));
        chk($sformatf("m_b_rvalid c%0d", cyc), 32'(b_rvalid), 32'(ebrv));
        chk($sformatf("m_rdata c%0d", cyc), 32'(rdata), 32'(exp_rd));
        cyc++;
    endtask

    // Directed vectors: inputs before an edge, outputs expected after it
    typedef struct {
        logic          ar, aw;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          br, bw;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [3:0]    ex;
        logic [DW-1:0] erd;
        logic [AW-1:0] eadd;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic ar, input logic aw, input logic [AW-1:0] aa,
                     input logic [DW-1:0] ad, input logic br, input logic bw,
                     input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input logic [3:0] ex, input logic [DW-1:0] erd,
                     input logic [AW-1:0] eadd);
        vec_t t;
        t.ar = ar; t.aw = aw; t.aa = aa; t.ad = ad;
        t.br = br; t.bw = bw; t.ba = ba; t.bd = bd;
        t.ex = ex; t.erd = erd; t.eadd = eadd;
        tv.push_back(t);
    endtask

    task automatic idle_row(input logic [3:0] ex, input logic [DW-1:0] erd);
        v(1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0, ex, erd, 6'd0);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int s;
        s = $urandom_range(0, 3);
        if (s == 0) return '0;
        if (s == 1) return '1;
        return AW'($urandom_range(1, 3));
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mm[i] = '0;
        clr = 1'b1; rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        @(posedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        chk("reset_flags", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);
        chk("reset_ram_ctl", 32'({ram_r_w, ram_enable, ram_ce}), 32'd0);
        chk("reset_ram_add", 32'(ram_add), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        rst_n = 1'b1;

        v(1, 1, 6'd5, 16'h1234, 0, 0, 6'd0, 16'h0, 4'b1000, 16'h0000, 6'd5);
        idle_row(4'b0000, 16'h0000);
        v(1, 0, 6'd5, 16'h0000, 0, 0, 6'd0, 16'h0, 4'b1000, 16'h0000, 6'd5);
        idle_row(4'b0000, 16'h0000);
        idle_row(4'b0010, 16'h1234);
        v(0, 0, 6'd0, 16'h0000, 1, 1, 6'd63, 16'hBEEF, 4'b0100, 16'h1234, 6'd63);
        idle_row(4'b0000, 16'h1234);
        v(1, 0, 6'd63, 16'h0000, 0, 0, 6'd0, 16'h0, 4'b1000, 16'h1234, 6'd63);
        idle_row(4'b0000, 16'h1234);
        idle_row(4'b0010, 16'hBEEF);
        idle_row(4'b0000, 16'hBEEF);
        v(1, 1, 6'd0, 16'h0001, 0, 0, 6'd0, 16'h0, 4'b1000, 16'hBEEF, 6'd0);
        v(0, 0, 6'd0, 16'h0000, 1, 1, 6'd10, 16'hAAAA, 4'b0000, 16'hBEEF, 6'd0);
        v(0, 0, 6'd0, 16'h0000, 1, 1, 6'd10, 16'hAAAA, 4'b0100, 16'hBEEF, 6'd10);
        idle_row(4'b0000, 16'hBEEF);
        for (int k = 0; k < 5; k++) begin
            v(1, 1, 6'd1, 16'h1111, 1, 1, 6'd2, 16'h2222,
              (k == 0 || k == 4) ? 4'b1000 : (k == 2) ? 4'b0100 : 4'b0000,
              16'hBEEF, (k == 2) ? 6'd2 : 6'd1);
        end
        idle_row(4'b0000, 16'hBEEF);
        v(1, 0, 6'd0, 16'h0000, 0, 0, 6'd0, 16'h0, 4'b1000, 16'hBEEF, 6'd0);
        idle_row(4'b0000, 16'hBEEF);
        idle_row(4'b0010, 16'h0001);
        idle_row(4'b0000, 16'h0001);

        foreach (tv[i]) begin
            a_req = tv[i].ar; a_we = tv[i].aw; a_addr = tv[i].aa; a_wdata = tv[i].ad;
            b_req = tv[i].br; b_we = tv[i].bw; b_addr = tv[i].ba; b_wdata = tv[i].bd;
            @(posedge clk); #1;
            chk($sformatf("row%0d_flags", i),
                32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'(tv[i].ex));
            chk($sformatf("row%0d_rdata", i), 32'(rdata), 32'(tv[i].erd));
            if (tv[i].ex[3] || tv[i].ex[2]) begin
                chk($sformatf("row%0d_ram_add", i), 32'(ram_add), 32'(tv[i].eadd));
                if (tv[i].ex[3] && tv[i].aw) mm[tv[i].aa] = tv[i].ad;
                if (tv[i].ex[2] && tv[i].bw) mm[tv[i].ba] = tv[i].bd;
            end
        end
        a_req = 0; b_req = 0;

        // Reset while the read sits in RDWAIT
        a_req = 1; a_we = 0; a_addr = 6'd5;
        @(posedge clk); #1;
        chk("mr_gnt", 32'(a_gnt), 32'd1);
        a_req = 0;
        @(posedge clk); #1;
        chk("mr_access_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_flags", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'd0);
        chk("mr_rst_ram_ctl", 32'({ram_r_w, ram_enable, ram_ce}), 32'd0);
        chk("mr_rst_ram_add", 32'(ram_add), 32'd0);
        chk("mr_rst_ram_data_in", 32'(ram_data_in), 32'd0);
        chk("mr_rst_rdata", 32'(rdata), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("mr_no_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        end
        rst_n = 1'b1;
        model_reset();

        // Held tie of reads after reset
        order.delete();
        a_req = 1; a_we = 0; a_addr = 6'd5;
        b_req = 1; b_we = 0; b_addr = 6'd63;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            step_check();
        end
        chk("tie_count", 32'(order.size()), 32'd4);
        if (order.size() == 4)
            chk("tie_order", 32'({order[0], order[1], order[2], order[3]}), 32'b0101);
        a_req = 0; b_req = 0;

        // Random traffic honouring the hold-until-grant rule
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            step_check();
            if (a_gnt || !a_req) begin
                a_req   = ($urandom_range(0, 2) != 0);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = pick_addr();
                a_wdata = 16'($urandom);
            end
            if (b_gnt || !b_req) begin
                b_req   = ($urandom_range(0, 2) != 0);
                b_we    = 1'($urandom_range(0, 1));
                b_addr  = pick_addr();
                b_wdata = 16'($urandom);
            end
        end
        a_req = 0; b_req = 0;
        repeat (4) begin
            @(posedge clk); #1;
            step_check();
        end
        chk("drain_pending", 32'(pend.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, address width matching the 64-word RAM.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Ports, listed in this order:

| Name | Dir | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | clock; all state on rising edge |
| rst_n | in | 1 | reset, asynchronous, active-low |
| a_req | in | 1 | requester A (fetch) access request |
| a_we | in | 1 | A: 1 = write, 0 = read |
| a_addr | in | ADDR_W | A address |
| a_wdata | in | DATA_W | A write data |
| a_gnt | out | 1 | A command accepted; 1-cycle pulse |
| a_rvalid | out | 1 | A read data valid on rdata; 1-cycle pulse |
| b_req, b_we, b_addr, b_wdata | in | as A | requester B (data) |
| b_gnt, b_rvalid | out | 1 | requester B, as for A |
| rdata | out | DATA_W | read data; shared by A and B, qualified by a_rvalid/b_rvalid |
| ram_add | out | ADDR_W | RAM address |
| ram_data_in | out | DATA_W | RAM write data |
| ram_r_w | out | 1 | RAM direction; 0 = read, 1 = write |
| ram_enable | out | 1 | RAM enable |
| ram_ce | out | 1 | RAM process enable |
| ram_data_out | in | DATA_W | RAM registered read data, valid 1 cycle after the read edge |

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, RDWAIT.
REQ-005 IDLE with neither request active: all RAM and requester outputs 0; stay IDLE.
REQ-006 IDLE with any request active: at the rising edge, the arbiter SHALL perform all of the following:
- select the winner;
- register the winner's addr/wdata/we onto ram_add/ram_data_in/ram_r_w;
- set ram_enable=1 and ram_ce=1;
- pulse the winner's gnt;
- record the owner;
- go to ACCESS.
REQ-007 Winner selection: a single active request wins. If both are active, the requester that did not win the previous grant wins (round-robin).
REQ-008 last_winner SHALL update only on a grant.
REQ-009 ACCESS: the RAM executes at this edge. At the same edge:
- ram_enable, ram_ce and gnt SHALL return to 0;
- next state is RDWAIT if ram_r_w=0, else IDLE.
REQ-010 RDWAIT: at the edge, the arbiter SHALL:
- capture ram_data_out into rdata;
- pulse the owner's rvalid for exactly one cycle;
- go to IDLE.
REQ-011 rdata SHALL hold its last value until the next read completes.
REQ-012 Latency, with request sampled at edge E0:
- gnt high E0..E1;
- read: rvalid high E2..E3, next acceptance at E3;
- write: RAM written at E1, next acceptance at E2.
REQ-013 Requests SHALL be sampled only in IDLE. req/we/addr/wdata presented in ACCESS or RDWAIT are ignored until IDLE.
REQ-014 Handshake rule: a requester holds req, we, addr and wdata stable until its gnt. It may drop or change them the cycle after gnt.
REQ-015 At most one of a_gnt/b_gnt SHALL be high in any cycle; likewise at most one of a_rvalid/b_rvalid.
REQ-016 gnt and rvalid SHALL never be high in the same cycle.
REQ-017 A requester that keeps req asserted continuously SHALL be granted within two arbitration rounds (no starvation).
REQ-018 Write-then-read ordering: a read issued after a write's gnt to the same address SHALL return the written data.
REQ-019 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously force:
- state to IDLE;
- all outputs to 0 (including rdata);
- last_winner to B, so that A wins the first tie.
REQ-021 Reset during ACCESS or RDWAIT SHALL abort the transaction: no rvalid is issued.
REQ-022 A RAM write already executed before reset remains in RAM.
REQ-023 The first acceptance after reset SHALL occur at the first rising edge with rst_n=1 and a request active.

Verification
REQ-024 A write then read: A writes 0x1234 @ addr 5, then reads addr 5. Required: a_gnt at E0 for the write; a_gnt at E2 for the read; a_rvalid at E4 with rdata=0x1234; no B activity.
REQ-025 Tie after reset: a_req=b_req=1 held continuously. Required grants A, B, A, B in that order, one grant per 2 cycles (writes) or 3 cycles (reads).
REQ-026 Read after another requester's write: B writes 0xBEEF @ 63, then A reads 63. Required: a_rvalid with rdata=0xBEEF; b_rvalid never asserted.
REQ-027 Reset mid-read: rst_n dropped in RDWAIT. Required: all outputs 0 immediately; no rvalid; after release, a tie grants A first.
REQ-028 Late request ignored: b_req raised during A's ACCESS cycle. Required: b_req ignored until IDLE; b_gnt exactly one cycle after the arbiter returns to IDLE (write case).
REQ-029 Address boundary: accesses to addresses 0 and 63. Required: ram_add equals the request address exactly; no wrap or truncation.
